// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU instruction-fetch and data channels onto a single memory bus.
// One transaction is in flight at a time; data requests win over fetches.
module cpu_mem_arbiter #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] PERF_INIT = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     PC,
    input  logic                  Inst_Req_Valid,
    output logic                  Inst_Req_Ready,
    output logic [DATA_W-1:0]     Instruction,
    output logic                  Inst_Valid,
    input  logic                  Inst_Ready,
    input  logic [ADDR_W-1:0]     Address,
    input  logic                  MemWrite,
    input  logic [DATA_W-1:0]     Write_data,
    input  logic [DATA_W/8-1:0]   Write_strb,
    input  logic                  MemRead,
    output logic                  Mem_Req_Ready,
    output logic [DATA_W-1:0]     Read_data,
    output logic                  Read_data_Valid,
    input  logic                  Read_data_Ready,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_wen,
    output logic                  bus_ren,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_rdata_valid,
    output logic                  bus_rdata_ready,
    output logic [31:0]           perf_bus_stall
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_r;
    logic   owner_data_r;
    logic   data_req_s;
    logic   resp_done_s;

    assign data_req_s  = MemRead | MemWrite;
    assign resp_done_s = owner_data_r ? Read_data_Ready : Inst_Ready;

    // Request readies follow the IDLE state; gating with rst keeps them low while reset is held.
    assign Mem_Req_Ready  = rst & (state_r == IDLE);
    assign Inst_Req_Ready = Mem_Req_Ready & ~data_req_s;

    // Transaction FSM with registered bus and response outputs plus the stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= IDLE;
            owner_data_r    <= 1'b0;
            bus_addr        <= {ADDR_W{1'b0}};
            bus_wen         <= 1'b0;
            bus_ren         <= 1'b0;
            bus_wdata       <= {DATA_W{1'b0}};
            bus_wstrb       <= {STRB_W{1'b0}};
            bus_req_valid   <= 1'b0;
            bus_rdata_ready <= 1'b0;
            Instruction     <= {DATA_W{1'b0}};
            Inst_Valid      <= 1'b0;
            Read_data       <= {DATA_W{1'b0}};
            Read_data_Valid <= 1'b0;
            perf_bus_stall  <= PERF_INIT;
        end else begin
            if ((state_r == REQ) || (state_r == WAIT)) begin
                perf_bus_stall <= perf_bus_stall + 32'd1;
            end
            case (state_r)
                IDLE: begin
                    if (data_req_s) begin
                        // A simultaneous read+write request is issued as a write.
                        bus_addr      <= Address;
                        bus_wdata     <= Write_data;
                        bus_wstrb     <= Write_strb;
                        bus_wen       <= MemWrite;
                        bus_ren       <= ~MemWrite;
                        owner_data_r  <= 1'b1;
                        bus_req_valid <= 1'b1;
                        state_r       <= REQ;
                    end else if (Inst_Req_Valid) begin
                        bus_addr      <= PC;
                        bus_wdata     <= {DATA_W{1'b0}};
                        bus_wstrb     <= {STRB_W{1'b0}};
                        bus_wen       <= 1'b0;
                        bus_ren       <= 1'b1;
                        owner_data_r  <= 1'b0;
                        bus_req_valid <= 1'b1;
                        state_r       <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        if (bus_wen) begin
                            state_r <= IDLE;
                        end else begin
                            bus_rdata_ready <= 1'b1;
                            state_r         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rdata_valid) begin
                        bus_rdata_ready <= 1'b0;
                        if (owner_data_r) begin
                            Read_data       <= bus_rdata;
                            Read_data_Valid <= 1'b1;
                        end else begin
                            Instruction <= bus_rdata;
                            Inst_Valid  <= 1'b1;
                        end
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (resp_done_s) begin
                        Inst_Valid      <= 1'b0;
                        Read_data_Valid <= 1'b0;
                        state_r         <= IDLE;
                    end
                end
                default: begin
                    bus_req_valid   <= 1'b0;
                    bus_rdata_ready <= 1'b0;
                    Inst_Valid      <= 1'b0;
                    Read_data_Valid <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Merges the CPU core's separate instruction-fetch and data-memory handshake channels onto one unified memory bus.
- Sits directly downstream of the custom CPU core and upstream of the memory/AXI bridge.
- Supports one outstanding transaction, with registered requests and responses.
- Data accesses have priority over instruction fetches.
- Counts bus stall cycles for the performance counters.

Parameters:
- ADDR_W, 32, address width of CPU and bus channels
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- PC  in  ADDR_W  fetch address from CPU
- Inst_Req_Valid  in  1  fetch request valid
- Inst_Req_Ready  out  1  fetch request accepted
- Instruction  out  DATA_W  fetched instruction
- Inst_Valid  out  1  instruction response valid
- Inst_Ready  in  1  CPU accepts instruction
- Address  in  ADDR_W  data address
- MemWrite  in  1  data write request
- Write_data  in  DATA_W  store data
- Write_strb  in  DATA_W/8  byte enables
- MemRead  in  1  data read request
- Mem_Req_Ready  out  1  data request accepted
- Read_data  out  DATA_W  load data
- Read_data_Valid  out  1  load response valid
- Read_data_Ready  in  1  CPU accepts load data
- bus_addr  out  ADDR_W  bus address (registered)
- bus_wen  out  1  bus write
- bus_ren  out  1  bus read
- bus_wdata  out  DATA_W  bus write data
- bus_wstrb  out  DATA_W/8  bus byte enables
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus request accepted
- bus_rdata  in  DATA_W  bus read data
- bus_rdata_valid  in  1  bus read data valid
- bus_rdata_ready  out  1  arbiter accepts read data
- perf_bus_stall  out  32  cycles spent in REQ or WAIT

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0, including perf_bus_stall, the latched address/data/strb registers, and the owner flag.
  - Reset asserted mid-transaction aborts it with no response to the CPU.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Mem_Req_Ready=1.
  - Inst_Req_Ready = ~(MemRead|MemWrite).
  - Data request (MemRead|MemWrite) wins over Inst_Req_Valid in the same cycle.
  - MemRead and MemWrite both high is treated as a write.
  - On data accept: latch Address, Write_data, Write_strb, bus_wen=MemWrite, bus_ren=~MemWrite, owner=DATA; go to REQ.
  - On fetch accept: latch PC, bus_ren=1, bus_wen=0, wstrb=0, owner=INST; go to REQ.
  - No request: stay in IDLE.
- REQ:
  - bus_req_valid=1; all CPU-side readies 0.
  - On bus_req_ready=1: write goes to IDLE (no CPU response); read goes to WAIT.
  - bus_req_valid falls in the cycle after acceptance.
- WAIT:
  - bus_rdata_ready=1.
  - On bus_rdata_valid=1: capture bus_rdata into the response register; go to RESP.
- RESP:
  - Drive the response register on Instruction (owner=INST) or Read_data (owner=DATA).
  - Assert only the matching Inst_Valid or Read_data_Valid; hold until the matching ready=1, then go to IDLE.
  - Valid deasserts the cycle after the handshake.
  - A new request may be accepted no earlier than the first IDLE cycle.
- Latency, zero-wait bus: accept at cycle N, bus_req_valid at N+1, rdata captured at N+2, CPU valid at N+3.
  - A write completes on the bus at N+1.
- Bus-side outputs are registered and stable while bus_req_valid=1 and not yet accepted.
- perf_bus_stall:
  - +1 in every cycle where state is REQ or WAIT.
  - Wraps 0xFFFFFFFF to 0; never cleared except by reset.
- Ignored inputs:
  - bus_rdata_valid outside WAIT.
  - Inst_Ready/Read_data_Ready outside RESP.

Test Plan:
- Fetch, zero-wait bus: PC=0x0000_0100, bus returns 0x0000_0013 -> Inst_Valid=1 with Instruction=0x13 three cycles after accept; bus_addr=0x100, bus_ren=1.
- Simultaneous MemRead@0x2000 and Inst_Req_Valid@0x104 -> Inst_Req_Ready=0, Mem_Req_Ready=1. Data read completes first (Read_data=bus value); fetch of 0x104 is accepted in the next IDLE cycle.
- Store with bus_req_ready held low 5 cycles: Address=0x3004, Write_data=0xDEADBEEF, strb=0xC -> bus_* stable for 5 cycles, no CPU response, return to IDLE; perf_bus_stall increments by 6.
- Read response back-pressure: Read_data_Ready low 4 cycles -> Read_data_Valid and Read_data held constant; both readies stay 0.
- Reset mid-WAIT: rst low asynchronously -> all outputs 0 immediately, state IDLE. A late bus_rdata_valid after reset release is ignored.
- perf_bus_stall starting from 0xFFFFFFFE with two stall cycles -> value becomes 0x00000000.
